// File: rtl/breakpoint_trigger_csr.sv
// Trigger CSR bank (tselect/tdata1/tdata2) for two breakpoints feeding the match unit.
// Optional hit counter CSR at 0x7A3 is enabled by defining BP_HIT_COUNT_EN.
module breakpoint_trigger_csr #(
  parameter int NUM_BP     = 2,
  parameter int XLEN       = 32,
  parameter int BPAMASKMAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            io_req_valid,
  output logic            io_req_ready,
  input  logic [1:0]      io_req_cmd,
  input  logic [11:0]     io_req_addr,
  input  logic [XLEN-1:0] io_req_wdata,
  output logic            io_resp_valid,
  output logic [XLEN-1:0] io_resp_rdata,
  output logic            io_resp_illegal,
  input  logic            io_status_debug,
  input  logic [1:0]      io_status_prv,
  output logic [3:0]      io_bp_0_control_tdrtype,
  output logic [4:0]      io_bp_0_control_bpamaskmax,
  output logic [3:0]      io_bp_0_control_reserved,
  output logic [7:0]      io_bp_0_control_bpaction,
  output logic [3:0]      io_bp_0_control_bpmatch,
  output logic            io_bp_0_control_m,
  output logic            io_bp_0_control_h,
  output logic            io_bp_0_control_s,
  output logic            io_bp_0_control_u,
  output logic            io_bp_0_control_r,
  output logic            io_bp_0_control_w,
  output logic            io_bp_0_control_x,
  output logic [XLEN-1:0] io_bp_0_address,
  output logic [3:0]      io_bp_1_control_tdrtype,
  output logic [4:0]      io_bp_1_control_bpamaskmax,
  output logic [3:0]      io_bp_1_control_reserved,
  output logic [7:0]      io_bp_1_control_bpaction,
  output logic [3:0]      io_bp_1_control_bpmatch,
  output logic            io_bp_1_control_m,
  output logic            io_bp_1_control_h,
  output logic            io_bp_1_control_s,
  output logic            io_bp_1_control_u,
  output logic            io_bp_1_control_r,
  output logic            io_bp_1_control_w,
  output logic            io_bp_1_control_x,
  output logic [XLEN-1:0] io_bp_1_address,
  input  logic            io_hit_valid,
  input  logic            io_xcpt_if,
  input  logic            io_xcpt_ld,
  input  logic            io_xcpt_st
);

  localparam logic [11:0] ADDR_TSELECT = 12'h7A0;
  localparam logic [11:0] ADDR_TDATA1  = 12'h7A1;
  localparam logic [11:0] ADDR_TDATA2  = 12'h7A2;
  localparam logic [1:0]  CMD_READ     = 2'd0;
  localparam logic [1:0]  CMD_WRITE    = 2'd1;
  localparam logic [1:0]  CMD_SET      = 2'd2;
  localparam logic [0:0]  ST_IDLE      = 1'b0;
  localparam logic [0:0]  ST_RESP      = 1'b1;
  localparam logic [3:0]  TDRTYPE      = 4'h2;
  localparam logic [4:0]  BPAMASK      = 5'(BPAMASKMAX);

  logic [0:0]            state_reg;
  logic                  tselect_reg;
  logic [XLEN-1:0]       resp_rdata_reg;
  logic                  resp_illegal_reg;
  logic [NUM_BP*10-1:0]  ctrl_vec;
  logic [NUM_BP*XLEN-1:0] addr_vec;
  logic [9:0]            ctrl_sel;
  logic [XLEN-1:0]       addr_sel;
  logic                  addr_ok;
  logic                  illegal;
  logic                  accept;
  logic                  do_write;
  logic                  is_write;
  logic [XLEN-1:0]       old_val;
  logic [XLEN-1:0]       new_val;

  // Control packed as {bpmatch[3:0], m, s, u, r, w, x}; constant fields are rebuilt on read.
  function automatic logic [31:0] tdata1_of(input logic [9:0] c);
    return {TDRTYPE, BPAMASK, 4'h0, 8'h00, c[9:6], c[5], 1'b0, c[4:0]};
  endfunction

`ifdef BP_HIT_COUNT_EN
  localparam logic [11:0] ADDR_HITCNT = 12'h7A3;
  logic [15:0] hit_cnt_reg;
  logic        hit_inc;
  assign hit_inc = io_hit_valid && (io_xcpt_if || io_xcpt_ld || io_xcpt_st);
`else
  logic unused_hit_inputs;
  assign unused_hit_inputs = ^{io_hit_valid, io_xcpt_if, io_xcpt_ld, io_xcpt_st};
`endif

  assign ctrl_sel = tselect_reg ? ctrl_vec[19:10] : ctrl_vec[9:0];
  assign addr_sel = tselect_reg ? addr_vec[2*XLEN-1:XLEN] : addr_vec[XLEN-1:0];

  always_comb begin
    addr_ok = 1'b1;
    old_val = '0;
    case (io_req_addr)
      ADDR_TSELECT: old_val = {{(XLEN-1){1'b0}}, tselect_reg};
      ADDR_TDATA1:  old_val = tdata1_of(ctrl_sel);
      ADDR_TDATA2:  old_val = addr_sel;
`ifdef BP_HIT_COUNT_EN
      ADDR_HITCNT:  old_val = {{(XLEN-16){1'b0}}, hit_cnt_reg};
`endif
      default:      addr_ok = 1'b0;
    endcase
  end

  always_comb begin
    case (io_req_cmd)
      CMD_READ:  new_val = old_val;
      CMD_WRITE: new_val = io_req_wdata;
      CMD_SET:   new_val = old_val | io_req_wdata;
      default:   new_val = old_val & ~io_req_wdata;
    endcase
  end

  assign is_write = (io_req_cmd != CMD_READ);
  assign illegal  = !addr_ok || (is_write && !io_status_debug && (io_status_prv != 2'b11));
  assign accept   = io_req_valid && (state_reg == ST_IDLE);
  assign do_write = accept && !illegal && is_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      resp_rdata_reg   <= '0;
      resp_illegal_reg <= 1'b0;
    end else if (state_reg == ST_RESP) begin
      state_reg <= ST_IDLE;
    end else if (accept) begin
      state_reg        <= ST_RESP;
      resp_rdata_reg   <= illegal ? '0 : old_val;
      resp_illegal_reg <= illegal;
    end
  end

  // Out-of-range tselect writes are ignored rather than truncated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tselect_reg <= 1'b0;
    end else if (do_write && (io_req_addr == ADDR_TSELECT) && (new_val < XLEN'(NUM_BP))) begin
      tselect_reg <= new_val[0];
    end
  end

  for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_bp
    logic [9:0]      ctrl_reg;
    logic [XLEN-1:0] address_reg;
    logic [3:0]      bpmatch_next;
    logic            sel;

    assign sel = (tselect_reg == 1'(gi));

    // Range match exists only on bp1; on bp0 it degrades to exact match.
    always_comb begin
      bpmatch_next = ctrl_reg[9:6];
      case (new_val[10:7])
        4'd0, 4'd2: bpmatch_next = new_val[10:7];
        4'd1:       bpmatch_next = (gi == 1) ? 4'd1 : 4'd0;
        default:    bpmatch_next = ctrl_reg[9:6];
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        ctrl_reg    <= '0;
        address_reg <= '0;
      end else if (do_write && sel) begin
        if (io_req_addr == ADDR_TDATA1)
          ctrl_reg <= {bpmatch_next, new_val[6], new_val[4:0]};
        if (io_req_addr == ADDR_TDATA2)
          address_reg <= new_val;
      end
    end

    assign ctrl_vec[10*gi +: 10]     = ctrl_reg;
    assign addr_vec[XLEN*gi +: XLEN] = address_reg;
  end

`ifdef BP_HIT_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_reg <= '0;
    end else if (do_write && (io_req_addr == ADDR_HITCNT)) begin
      hit_cnt_reg <= new_val[15:0];
    end else if (hit_inc && (hit_cnt_reg != 16'hFFFF)) begin
      hit_cnt_reg <= hit_cnt_reg + 16'd1;
    end
  end
`endif

  assign io_req_ready    = (state_reg == ST_IDLE);
  assign io_resp_valid   = (state_reg == ST_RESP);
  assign io_resp_rdata   = resp_rdata_reg;
  assign io_resp_illegal = resp_illegal_reg;

  assign io_bp_0_control_tdrtype    = TDRTYPE;
  assign io_bp_0_control_bpamaskmax = BPAMASK;
  assign io_bp_0_control_reserved   = 4'h0;
  assign io_bp_0_control_bpaction   = 8'h00;
  assign io_bp_0_control_bpmatch    = ctrl_vec[9:6];
  assign io_bp_0_control_m          = ctrl_vec[5];
  assign io_bp_0_control_h          = 1'b0;
  assign io_bp_0_control_s          = ctrl_vec[4];
  assign io_bp_0_control_u          = ctrl_vec[3];
  assign io_bp_0_control_r          = ctrl_vec[2];
  assign io_bp_0_control_w          = ctrl_vec[1];
  assign io_bp_0_control_x          = ctrl_vec[0];
  assign io_bp_0_address            = addr_vec[XLEN-1:0];

  assign io_bp_1_control_tdrtype    = TDRTYPE;
  assign io_bp_1_control_bpamaskmax = BPAMASK;
  assign io_bp_1_control_reserved   = 4'h0;
  assign io_bp_1_control_bpaction   = 8'h00;
  assign io_bp_1_control_bpmatch    = ctrl_vec[19:16];
  assign io_bp_1_control_m          = ctrl_vec[15];
  assign io_bp_1_control_h          = 1'b0;
  assign io_bp_1_control_s          = ctrl_vec[14];
  assign io_bp_1_control_u          = ctrl_vec[13];
  assign io_bp_1_control_r          = ctrl_vec[12];
  assign io_bp_1_control_w          = ctrl_vec[11];
  assign io_bp_1_control_x          = ctrl_vec[10];
  assign io_bp_1_address            = addr_vec[2*XLEN-1:XLEN];

endmodule

// File: tb/tb_breakpoint_trigger_csr.sv
// Directed self-checking bench for breakpoint_trigger_csr; hit-counter checks run when BP_HIT_COUNT_EN is defined.
module tb_breakpoint_trigger_csr;
  logic        clk = 1'b0;
  logic        reset;
  logic        io_req_valid;
  logic        io_req_ready;
  logic [1:0]  io_req_cmd;
  logic [11:0] io_req_addr;
  logic [31:0] io_req_wdata;
  logic        io_resp_valid;
  logic [31:0] io_resp_rdata;
  logic        io_resp_illegal;
  logic        io_status_debug;
  logic [1:0]  io_status_prv;
  logic [3:0]  bp0_tdrtype, bp1_tdrtype, bp0_reserved, bp1_reserved, bp0_bpmatch, bp1_bpmatch;
  logic [4:0]  bp0_bpamaskmax, bp1_bpamaskmax;
  logic [7:0]  bp0_bpaction, bp1_bpaction;
  logic        bp0_m, bp0_h, bp0_s, bp0_u, bp0_r, bp0_w, bp0_x;
  logic        bp1_m, bp1_h, bp1_s, bp1_u, bp1_r, bp1_w, bp1_x;
  logic [31:0] bp0_address, bp1_address;
  logic        io_hit_valid, io_xcpt_if, io_xcpt_ld, io_xcpt_st;

  int passed = 0;
  int total  = 0;

  breakpoint_trigger_csr dut (
    .clk(clk), .reset(reset),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready), .io_req_cmd(io_req_cmd),
    .io_req_addr(io_req_addr), .io_req_wdata(io_req_wdata),
    .io_resp_valid(io_resp_valid), .io_resp_rdata(io_resp_rdata), .io_resp_illegal(io_resp_illegal),
    .io_status_debug(io_status_debug), .io_status_prv(io_status_prv),
    .io_bp_0_control_tdrtype(bp0_tdrtype), .io_bp_0_control_bpamaskmax(bp0_bpamaskmax),
    .io_bp_0_control_reserved(bp0_reserved), .io_bp_0_control_bpaction(bp0_bpaction),
    .io_bp_0_control_bpmatch(bp0_bpmatch), .io_bp_0_control_m(bp0_m), .io_bp_0_control_h(bp0_h),
    .io_bp_0_control_s(bp0_s), .io_bp_0_control_u(bp0_u), .io_bp_0_control_r(bp0_r),
    .io_bp_0_control_w(bp0_w), .io_bp_0_control_x(bp0_x), .io_bp_0_address(bp0_address),
    .io_bp_1_control_tdrtype(bp1_tdrtype), .io_bp_1_control_bpamaskmax(bp1_bpamaskmax),
    .io_bp_1_control_reserved(bp1_reserved), .io_bp_1_control_bpaction(bp1_bpaction),
    .io_bp_1_control_bpmatch(bp1_bpmatch), .io_bp_1_control_m(bp1_m), .io_bp_1_control_h(bp1_h),
    .io_bp_1_control_s(bp1_s), .io_bp_1_control_u(bp1_u), .io_bp_1_control_r(bp1_r),
    .io_bp_1_control_w(bp1_w), .io_bp_1_control_x(bp1_x), .io_bp_1_address(bp1_address),
    .io_hit_valid(io_hit_valid), .io_xcpt_if(io_xcpt_if), .io_xcpt_ld(io_xcpt_ld), .io_xcpt_st(io_xcpt_st)
  );

  always #5 clk = ~clk;

  // Issue one request from IDLE and sample the response in the following cycle.
  task automatic access(input logic [1:0] cmd, input logic [11:0] addr, input logic [31:0] wdata,
                        output logic rvalid, output logic [31:0] rdata, output logic ill);
    int n = 0;
    io_req_valid = 1'b1; io_req_cmd = cmd; io_req_addr = addr; io_req_wdata = wdata;
    while (!io_req_ready && n < 10) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    io_req_valid = 1'b0;
    rvalid = io_resp_valid; rdata = io_resp_rdata; ill = io_resp_illegal;
    $display("txn cmd=%0d addr=%h wdata=%h -> valid=%0b rdata=%h illegal=%0b", cmd, addr, wdata, rvalid, rdata, ill);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic v, il; logic [31:0] d;
    total++; if (io_req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", io_req_ready); else passed++;
    total++; if (io_resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", io_resp_valid); else passed++;
    total++; if ({io_resp_rdata, io_resp_illegal} !== 33'h0) $display("FAIL reset_resp: got %h/%b want 0/0", io_resp_rdata, io_resp_illegal); else passed++;
    total++; if ({bp0_m, bp0_s, bp0_u, bp0_r, bp0_w, bp0_x, bp1_m, bp1_s, bp1_u, bp1_r, bp1_w, bp1_x} !== 12'h0)
      $display("FAIL reset_enables: got nonzero want 0"); else passed++;
    total++; if ({bp0_bpmatch, bp1_bpmatch, bp0_address, bp1_address} !== 72'h0) $display("FAIL reset_match_addr: got nonzero want 0"); else passed++;
    total++; if ({bp0_tdrtype, bp0_bpamaskmax, bp1_tdrtype, bp1_bpamaskmax, bp0_h} !== {4'h2, 5'd4, 4'h2, 5'd4, 1'b0})
      $display("FAIL reset_const: got %h/%h want 2/4", bp0_tdrtype, bp0_bpamaskmax); else passed++;
    access(2'd0, 12'h7A1, 32'h0, v, d, il);
    total++; if (v !== 1'b1) $display("FAIL rd_tdata1_valid: got %b want 1", v); else passed++;
    total++; if (d !== 32'h2200_0000) $display("FAIL rd_tdata1_reset: got %h want 22000000", d); else passed++;
    total++; if (il !== 1'b0) $display("FAIL rd_tdata1_illegal: got %b want 0", il); else passed++;
    access(2'd0, 12'h7A0, 32'h0, v, d, il);
    total++; if (d !== 32'h0) $display("FAIL rd_tselect_reset: got %h want 0", d); else passed++;
  endtask

  task automatic test_bp1_write();
    logic v, il; logic [31:0] d;
    io_status_prv = 2'd3; io_status_debug = 1'b0;
    access(2'd1, 12'h7A0, 32'h1, v, d, il);
    total++; if ({il, d} !== 33'h0) $display("FAIL wr_tselect: got %b/%h want 0/0", il, d); else passed++;
    access(2'd1, 12'h7A1, 32'h0000_00C5, v, d, il);
    total++; if (d !== 32'h2200_0000) $display("FAIL wr_tdata1_old: got %h want 22000000", d); else passed++;
    total++; if ({bp1_bpmatch, bp1_m, bp1_s, bp1_u, bp1_r, bp1_w, bp1_x} !== {4'd1, 6'b100101})
      $display("FAIL bp1_ctrl: got %h %b%b%b%b%b%b want 1 100101", bp1_bpmatch, bp1_m, bp1_s, bp1_u, bp1_r, bp1_w, bp1_x); else passed++;
    total++; if ({bp0_bpmatch, bp0_m, bp0_r, bp0_x} !== 7'h0) $display("FAIL bp0_untouched: got %h want 0", {bp0_bpmatch, bp0_m, bp0_r, bp0_x}); else passed++;
    access(2'd2, 12'h7A1, 32'h8, v, d, il);
    total++; if (d !== 32'h2200_00C5) $display("FAIL set_old: got %h want 220000c5", d); else passed++;
    access(2'd3, 12'h7A1, 32'h1, v, d, il);
    total++; if (d !== 32'h2200_00CD) $display("FAIL clear_old: got %h want 220000cd", d); else passed++;
    access(2'd1, 12'h7A1, 32'hFFFF_FFFF, v, d, il);
    total++; if (d !== 32'h2200_00CC) $display("FAIL after_clear: got %h want 220000cc", d); else passed++;
    access(2'd0, 12'h7A1, 32'h0, v, d, il);
    total++; if (d !== 32'h2200_00DF) $display("FAIL const_fields: got %h want 220000df", d); else passed++;
    access(2'd1, 12'h7A2, 32'h1234_5678, v, d, il);
    total++; if ({bp1_address, bp0_address} !== {32'h1234_5678, 32'h0}) $display("FAIL bp1_addr: got %h/%h want 12345678/0", bp1_address, bp0_address); else passed++;
  endtask

  task automatic test_bp0_warl();
    logic v, il; logic [31:0] d;
    access(2'd1, 12'h7A0, 32'h0, v, d, il);
    total++; if (d !== 32'h1) $display("FAIL tselect_old: got %h want 1", d); else passed++;
    access(2'd1, 12'h7A0, 32'h2, v, d, il);
    access(2'd0, 12'h7A0, 32'h0, v, d, il);
    total++; if (d !== 32'h0) $display("FAIL tselect_warl: got %h want 0", d); else passed++;
    access(2'd1, 12'h7A1, 32'h80, v, d, il);
    total++; if (bp0_bpmatch !== 4'd0) $display("FAIL bp0_range_to_exact: got %h want 0", bp0_bpmatch); else passed++;
    access(2'd1, 12'h7A1, 32'h100, v, d, il);
    total++; if (bp0_bpmatch !== 4'd2) $display("FAIL bp0_napot: got %h want 2", bp0_bpmatch); else passed++;
    access(2'd1, 12'h7A1, 32'h280, v, d, il);
    access(2'd0, 12'h7A1, 32'h0, v, d, il);
    total++; if (d !== 32'h2200_0100) $display("FAIL bp0_illegal_keep: got %h want 22000100", d); else passed++;
    total++; if (bp1_bpmatch !== 4'd1) $display("FAIL bp1_still_range: got %h want 1", bp1_bpmatch); else passed++;
  endtask

  task automatic test_privilege();
    logic v, il; logic [31:0] d;
    io_status_prv = 2'd0; io_status_debug = 1'b0;
    access(2'd1, 12'h7A2, 32'hDEAD_BEEF, v, d, il);
    total++; if ({il, d} !== {1'b1, 32'h0}) $display("FAIL user_write: got %b/%h want 1/0", il, d); else passed++;
    total++; if (bp0_address !== 32'h0) $display("FAIL user_write_addr: got %h want 0", bp0_address); else passed++;
    access(2'd2, 12'h7A1, 32'h0, v, d, il);
    total++; if (il !== 1'b1) $display("FAIL user_set_zero: got %b want 1", il); else passed++;
    access(2'd0, 12'h7A1, 32'h0, v, d, il);
    total++; if ({il, d} !== {1'b0, 32'h2200_0100}) $display("FAIL user_read: got %b/%h want 0/22000100", il, d); else passed++;
    io_status_debug = 1'b1;
    access(2'd1, 12'h7A2, 32'hDEAD_BEEF, v, d, il);
    total++; if ({il, bp0_address} !== {1'b0, 32'hDEAD_BEEF}) $display("FAIL debug_write: got %b/%h want 0/deadbeef", il, bp0_address); else passed++;
  endtask

  task automatic test_illegal_addr();
    logic v, il; logic [31:0] d;
    access(2'd0, 12'h7A5, 32'h0, v, d, il);
    total++; if ({v, il, d} !== {2'b11, 32'h0}) $display("FAIL addr_7a5: got %b%b/%h want 11/0", v, il, d); else passed++;
`ifndef BP_HIT_COUNT_EN
    access(2'd0, 12'h7A3, 32'h0, v, d, il);
    total++; if ({il, d} !== {1'b1, 32'h0}) $display("FAIL addr_7a3_absent: got %b/%h want 1/0", il, d); else passed++;
`endif
  endtask

  task automatic test_back_to_back();
    io_req_valid = 1'b1; io_req_cmd = 2'd0; io_req_addr = 12'h7A0; io_req_wdata = 32'h0;
    total++; if (io_req_ready !== 1'b1) $display("FAIL b2b_ready0: got %b want 1", io_req_ready); else passed++;
    @(posedge clk); #1;
    total++; if ({io_resp_valid, io_req_ready, io_resp_rdata} !== {2'b10, 32'h0}) $display("FAIL b2b_resp1: got %b%b/%h want 10/0", io_resp_valid, io_req_ready, io_resp_rdata); else passed++;
    io_req_addr = 12'h7A2;
    @(posedge clk); #1;
    total++; if ({io_resp_valid, io_req_ready} !== 2'b01) $display("FAIL b2b_gap: got %b%b want 01", io_resp_valid, io_req_ready); else passed++;
    @(posedge clk); #1;
    io_req_valid = 1'b0;
    total++; if ({io_resp_valid, io_resp_rdata} !== {1'b1, 32'hDEAD_BEEF}) $display("FAIL b2b_resp2: got %b/%h want 1/deadbeef", io_resp_valid, io_resp_rdata); else passed++;
    $display("txn back-to-back pair done rdata=%h", io_resp_rdata);
    @(posedge clk); #1;
  endtask

`ifdef BP_HIT_COUNT_EN
  task automatic test_hit_count();
    logic v, il; logic [31:0] d;
    io_xcpt_ld = 1'b1;
    @(posedge clk); #1;
    io_hit_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 io_hit_valid = 1'b0; io_xcpt_ld = 1'b0;
    access(2'd0, 12'h7A3, 32'h0, v, d, il);
    total++; if ({il, d} !== {1'b0, 32'd3}) $display("FAIL hit_count3: got %b/%h want 0/3", il, d); else passed++;
    io_req_valid = 1'b1; io_req_cmd = 2'd1; io_req_addr = 12'h7A3; io_req_wdata = 32'h0;
    io_hit_valid = 1'b1; io_xcpt_st = 1'b1;
    @(posedge clk); #1;
    io_req_valid = 1'b0; io_hit_valid = 1'b0; io_xcpt_st = 1'b0;
    @(posedge clk); #1;
    access(2'd0, 12'h7A3, 32'h0, v, d, il);
    total++; if (d !== 32'd0) $display("FAIL hit_write_priority: got %h want 0", d); else passed++;
  endtask
`endif

  task automatic test_reset_abort();
    io_req_valid = 1'b1; io_req_cmd = 2'd0; io_req_addr = 12'h7A1;
    @(posedge clk); #1;
    io_req_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    total++; if ({io_resp_valid, io_req_ready, io_resp_rdata} !== {2'b01, 32'h0}) $display("FAIL reset_abort: got %b%b/%h want 01/0", io_resp_valid, io_req_ready, io_resp_rdata); else passed++;
    total++; if ({bp1_m, bp1_bpmatch, bp1_address} !== 37'h0) $display("FAIL reset_clears_bp1: got nonzero want 0"); else passed++;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    $display("txn reset during response");
  endtask

  initial begin
    reset = 1'b1; io_req_valid = 1'b0; io_req_cmd = 2'd0; io_req_addr = 12'h0; io_req_wdata = 32'h0;
    io_status_debug = 1'b0; io_status_prv = 2'd3;
    io_hit_valid = 1'b0; io_xcpt_if = 1'b0; io_xcpt_ld = 1'b0; io_xcpt_st = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_bp1_write();
    test_bp0_warl();
    test_privilege();
    test_illegal_addr();
    test_back_to_back();
`ifdef BP_HIT_COUNT_EN
    test_hit_count();
`endif
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
